// File: rtl/axi_rr_arb_2to1_if.sv
// AXI4 bus bundle shared by the arbiter's upstream and downstream ports.
// Master drives requests, write data and response readies; Slave is the mirror.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 6
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_user, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
    input  b_id, b_resp, b_user, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid, input ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_user, aw_valid, output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid, output w_ready,
    output b_id, b_resp, b_user, b_valid, input b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
  );
endinterface

// File: rtl/axi_rr_arb_2to1.sv
// Two-to-one AXI4 arbiter. AW and AR are arbitrated round-robin independently,
// W follows the granted writer until w_last, and B/R are steered back by the
// port bit prepended to the downstream ID. Only grant/lock state is registered.
module axi_rr_arb_2to1 #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 6
) (
  input logic    clk,
  input logic    rst_n,
  AXI_BUS.Slave  slv0,
  AXI_BUS.Slave  slv1,
  AXI_BUS.Master mst
);

  typedef enum logic [1:0] {WR_IDLE, WR_AWHOLD, WR_DATA} wr_state_e;
  typedef enum logic       {RD_IDLE, RD_HOLD} rd_state_e;

  wr_state_e wr_state_reg, wr_state_next;
  logic      wsel_reg, wsel_next;
  logic      wr_ptr_reg, wr_ptr_next;
  rd_state_e rd_state_reg, rd_state_next;
  logic      rsel_reg, rsel_next;
  logic      rd_ptr_reg, rd_ptr_next;

  logic aw_gnt, aw_valid_sel, aw_open;
  logic ar_gnt, ar_valid_sel;
  logic w_valid_sel, w_last_sel, w_open;
  logic b_idx, r_idx;

  logic [AXI_ID_WIDTH-1:0]   aw_id_sel, ar_id_sel;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_sel, ar_addr_sel;
  logic [AXI_DATA_WIDTH-1:0] w_data_sel;
  logic [AXI_USER_WIDTH-1:0] w_user_sel;

  // Write grant/lock state; reset prefers port 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_reg <= WR_IDLE;
      wsel_reg     <= 1'b0;
      wr_ptr_reg   <= 1'b0;
    end else begin
      wr_state_reg <= wr_state_next;
      wsel_reg     <= wsel_next;
      wr_ptr_reg   <= wr_ptr_next;
    end
  end

  // Write arbitration: free choice in WR_IDLE, frozen grant until AW and the W burst finish.
  always_comb begin
    wr_state_next = wr_state_reg;
    wsel_next     = wsel_reg;
    wr_ptr_next   = wr_ptr_reg;
    aw_gnt        = wsel_reg;
    aw_valid_sel  = 1'b0;
    case (wr_state_reg)
      WR_IDLE: begin
        aw_gnt       = slv1.aw_valid & (~slv0.aw_valid | wr_ptr_reg);
        aw_valid_sel = slv0.aw_valid | slv1.aw_valid;
        if (aw_valid_sel) begin
          wsel_next = aw_gnt;
          if (mst.aw_ready) begin
            wr_state_next = WR_DATA;
            wr_ptr_next   = ~aw_gnt;
          end else begin
            wr_state_next = WR_AWHOLD;
          end
        end
      end
      WR_AWHOLD: begin
        aw_valid_sel = wsel_reg ? slv1.aw_valid : slv0.aw_valid;
        if (aw_valid_sel && mst.aw_ready) begin
          wr_state_next = WR_DATA;
          wr_ptr_next   = ~wsel_reg;
        end
      end
      WR_DATA: begin
        if (w_valid_sel && mst.w_ready && w_last_sel) begin
          wr_state_next = WR_IDLE;
        end
      end
      default: wr_state_next = WR_IDLE;
    endcase
  end

  // Read grant state; reset prefers port 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_reg <= RD_IDLE;
      rsel_reg     <= 1'b0;
      rd_ptr_reg   <= 1'b0;
    end else begin
      rd_state_reg <= rd_state_next;
      rsel_reg     <= rsel_next;
      rd_ptr_reg   <= rd_ptr_next;
    end
  end

  // Read arbitration: grant held only while a presented AR waits for its handshake.
  always_comb begin
    rd_state_next = rd_state_reg;
    rsel_next     = rsel_reg;
    rd_ptr_next   = rd_ptr_reg;
    ar_gnt        = rsel_reg;
    ar_valid_sel  = 1'b0;
    case (rd_state_reg)
      RD_IDLE: begin
        ar_gnt       = slv1.ar_valid & (~slv0.ar_valid | rd_ptr_reg);
        ar_valid_sel = slv0.ar_valid | slv1.ar_valid;
        if (ar_valid_sel) begin
          rsel_next = ar_gnt;
          if (mst.ar_ready) rd_ptr_next = ~ar_gnt;
          else              rd_state_next = RD_HOLD;
        end
      end
      RD_HOLD: begin
        ar_valid_sel = rsel_reg ? slv1.ar_valid : slv0.ar_valid;
        if (ar_valid_sel && mst.ar_ready) begin
          rd_state_next = RD_IDLE;
          rd_ptr_next   = ~rsel_reg;
        end
      end
    endcase
  end

  // AW forward path: selected port's fields, port index prepended to the ID.
  assign aw_open     = (wr_state_reg != WR_DATA);
  assign aw_id_sel   = aw_gnt ? slv1.aw_id   : slv0.aw_id;
  assign aw_addr_sel = aw_gnt ? slv1.aw_addr : slv0.aw_addr;
  assign mst.aw_id     = {aw_gnt, aw_id_sel};
  assign mst.aw_addr   = aw_addr_sel;
  assign mst.aw_len    = aw_gnt ? slv1.aw_len    : slv0.aw_len;
  assign mst.aw_size   = aw_gnt ? slv1.aw_size   : slv0.aw_size;
  assign mst.aw_burst  = aw_gnt ? slv1.aw_burst  : slv0.aw_burst;
  assign mst.aw_lock   = aw_gnt ? slv1.aw_lock   : slv0.aw_lock;
  assign mst.aw_cache  = aw_gnt ? slv1.aw_cache  : slv0.aw_cache;
  assign mst.aw_prot   = aw_gnt ? slv1.aw_prot   : slv0.aw_prot;
  assign mst.aw_qos    = aw_gnt ? slv1.aw_qos    : slv0.aw_qos;
  assign mst.aw_region = aw_gnt ? slv1.aw_region : slv0.aw_region;
  assign mst.aw_user   = aw_gnt ? slv1.aw_user   : slv0.aw_user;
  assign mst.aw_valid  = rst_n & aw_valid_sel;
  assign slv0.aw_ready = rst_n & aw_open & ~aw_gnt & mst.aw_ready;
  assign slv1.aw_ready = rst_n & aw_open &  aw_gnt & mst.aw_ready;

  // W forward path: only the locked writer is visible, and only in WR_DATA.
  assign w_open      = (wr_state_reg == WR_DATA);
  assign w_valid_sel = wsel_reg ? slv1.w_valid : slv0.w_valid;
  assign w_last_sel  = wsel_reg ? slv1.w_last  : slv0.w_last;
  assign w_data_sel  = wsel_reg ? slv1.w_data  : slv0.w_data;
  assign w_user_sel  = wsel_reg ? slv1.w_user  : slv0.w_user;
  assign mst.w_data   = w_data_sel;
  assign mst.w_strb   = wsel_reg ? slv1.w_strb : slv0.w_strb;
  assign mst.w_last   = w_last_sel;
  assign mst.w_user   = w_user_sel;
  assign mst.w_valid  = rst_n & w_open & w_valid_sel;
  assign slv0.w_ready = rst_n & w_open & ~wsel_reg & mst.w_ready;
  assign slv1.w_ready = rst_n & w_open &  wsel_reg & mst.w_ready;

  // AR forward path: same shape as AW, without a data lock.
  assign ar_id_sel   = ar_gnt ? slv1.ar_id   : slv0.ar_id;
  assign ar_addr_sel = ar_gnt ? slv1.ar_addr : slv0.ar_addr;
  assign mst.ar_id     = {ar_gnt, ar_id_sel};
  assign mst.ar_addr   = ar_addr_sel;
  assign mst.ar_len    = ar_gnt ? slv1.ar_len    : slv0.ar_len;
  assign mst.ar_size   = ar_gnt ? slv1.ar_size   : slv0.ar_size;
  assign mst.ar_burst  = ar_gnt ? slv1.ar_burst  : slv0.ar_burst;
  assign mst.ar_lock   = ar_gnt ? slv1.ar_lock   : slv0.ar_lock;
  assign mst.ar_cache  = ar_gnt ? slv1.ar_cache  : slv0.ar_cache;
  assign mst.ar_prot   = ar_gnt ? slv1.ar_prot   : slv0.ar_prot;
  assign mst.ar_qos    = ar_gnt ? slv1.ar_qos    : slv0.ar_qos;
  assign mst.ar_region = ar_gnt ? slv1.ar_region : slv0.ar_region;
  assign mst.ar_user   = ar_gnt ? slv1.ar_user   : slv0.ar_user;
  assign mst.ar_valid  = rst_n & ar_valid_sel;
  assign slv0.ar_ready = rst_n & ~ar_gnt & mst.ar_ready;
  assign slv1.ar_ready = rst_n &  ar_gnt & mst.ar_ready;

  // B return path: ID MSB picks the port, payload is broadcast.
  assign b_idx = mst.b_id[AXI_ID_WIDTH];
  assign slv0.b_id    = mst.b_id[AXI_ID_WIDTH-1:0];
  assign slv1.b_id    = mst.b_id[AXI_ID_WIDTH-1:0];
  assign slv0.b_resp  = mst.b_resp;
  assign slv1.b_resp  = mst.b_resp;
  assign slv0.b_user  = mst.b_user;
  assign slv1.b_user  = mst.b_user;
  assign slv0.b_valid = rst_n & mst.b_valid & ~b_idx;
  assign slv1.b_valid = rst_n & mst.b_valid &  b_idx;
  assign mst.b_ready  = b_idx ? slv1.b_ready : slv0.b_ready;

  // R return path: same steering as B, independent of any FSM state.
  assign r_idx = mst.r_id[AXI_ID_WIDTH];
  assign slv0.r_id    = mst.r_id[AXI_ID_WIDTH-1:0];
  assign slv1.r_id    = mst.r_id[AXI_ID_WIDTH-1:0];
  assign slv0.r_data  = mst.r_data;
  assign slv1.r_data  = mst.r_data;
  assign slv0.r_resp  = mst.r_resp;
  assign slv1.r_resp  = mst.r_resp;
  assign slv0.r_last  = mst.r_last;
  assign slv1.r_last  = mst.r_last;
  assign slv0.r_user  = mst.r_user;
  assign slv1.r_user  = mst.r_user;
  assign slv0.r_valid = rst_n & mst.r_valid & ~r_idx;
  assign slv1.r_valid = rst_n & mst.r_valid &  r_idx;
  assign mst.r_ready  = r_idx ? slv1.r_ready : slv0.r_ready;

endmodule

// File: tb/tb_axi_rr_arb_2to1.sv
// Bench for axi_rr_arb_2to1: handshake scoreboard on AW/AR/W, a response-routing
// vector table, and hand sequences for holds, burst lock and reset mid-burst.
module tb_axi_rr_arb_2to1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(6)) s0 ();
  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(6)) s1 ();
  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(11), .AXI_USER_WIDTH(6)) m ();

  axi_rr_arb_2to1 #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .slv0(s0), .slv1(s1), .mst(m));

  int checks = 0;
  int failures = 0;

  typedef struct packed {logic [10:0] id; logic [31:0] addr; logic [1:0] rdy;} a_exp_t;
  typedef struct packed {logic [63:0] data; logic last; logic [1:0] rdy;} w_exp_t;
  a_exp_t aw_q[$];
  a_exp_t ar_q[$];
  w_exp_t w_q[$];
  a_exp_t mon_a;
  w_exp_t mon_w;

  typedef struct {
    logic [10:0] r_id; logic r_valid; logic [1:0] r_rdy;
    logic [10:0] b_id; logic b_valid; logic [1:0] b_rdy;
    logic [1:0] exp_rv; logic exp_rr; logic [1:0] exp_bv; logic exp_br;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s: handshake seen with no entry queued (got 1 required 0)", name);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_aw(input int p, input logic v, input logic [9:0] id, input logic [31:0] addr,
                        input logic [7:0] len);
    if (p == 0) begin s0.aw_valid = v; s0.aw_id = id; s0.aw_addr = addr; s0.aw_len = len; end
    else        begin s1.aw_valid = v; s1.aw_id = id; s1.aw_addr = addr; s1.aw_len = len; end
  endtask

  task automatic set_ar(input int p, input logic v, input logic [9:0] id, input logic [31:0] addr);
    if (p == 0) begin s0.ar_valid = v; s0.ar_id = id; s0.ar_addr = addr; end
    else        begin s1.ar_valid = v; s1.ar_id = id; s1.ar_addr = addr; end
  endtask

  task automatic set_w(input int p, input logic v, input logic [63:0] d, input logic last);
    if (p == 0) begin s0.w_valid = v; s0.w_data = d; s0.w_last = last; s0.w_strb = 8'hFF; end
    else        begin s1.w_valid = v; s1.w_data = d; s1.w_last = last; s1.w_strb = 8'hFF; end
  endtask

  task automatic idle_all();
    set_aw(0, 1'b0, '0, '0, '0); set_aw(1, 1'b0, '0, '0, '0);
    set_ar(0, 1'b0, '0, '0);     set_ar(1, 1'b0, '0, '0);
    set_w(0, 1'b0, '0, 1'b0);    set_w(1, 1'b0, '0, 1'b0);
    s0.b_ready = 1'b0; s1.b_ready = 1'b0; s0.r_ready = 1'b0; s1.r_ready = 1'b0;
    m.aw_ready = 1'b0; m.ar_ready = 1'b0; m.w_ready = 1'b0;
    m.b_valid = 1'b0; m.b_id = '0; m.b_resp = '0; m.b_user = '0;
    m.r_valid = 1'b0; m.r_id = '0; m.r_data = '0; m.r_resp = '0; m.r_last = 1'b0; m.r_user = '0;
  endtask

  // Handshake monitor: every downstream handshake must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m.aw_valid && m.aw_ready) begin
        if (aw_q.size() == 0) flag("aw_hs");
        else begin
          mon_a = aw_q.pop_front();
          chk("aw_id", 64'(m.aw_id), 64'(mon_a.id));
          chk("aw_addr", 64'(m.aw_addr), 64'(mon_a.addr));
          chk("aw_ready_port", 64'({s1.aw_ready, s0.aw_ready}), 64'(mon_a.rdy));
        end
      end
      if (m.ar_valid && m.ar_ready) begin
        if (ar_q.size() == 0) flag("ar_hs");
        else begin
          mon_a = ar_q.pop_front();
          chk("ar_id", 64'(m.ar_id), 64'(mon_a.id));
          chk("ar_addr", 64'(m.ar_addr), 64'(mon_a.addr));
          chk("ar_ready_port", 64'({s1.ar_ready, s0.ar_ready}), 64'(mon_a.rdy));
        end
      end
      if (m.w_valid && m.w_ready) begin
        if (w_q.size() == 0) flag("w_hs");
        else begin
          mon_w = w_q.pop_front();
          chk("w_data", m.w_data, mon_w.data);
          chk("w_last", 64'(m.w_last), 64'(mon_w.last));
          chk("w_ready_port", 64'({s1.w_ready, s0.w_ready}), 64'(mon_w.rdy));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached (got timeout required completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    logic [63:0] rdat;
    vecs[0] = '{11'h405, 1'b1, 2'b10, 11'h003, 1'b1, 2'b01, 2'b10, 1'b1, 2'b01, 1'b1};
    vecs[1] = '{11'h007, 1'b1, 2'b10, 11'h404, 1'b1, 2'b01, 2'b01, 1'b0, 2'b10, 1'b0};
    vecs[2] = '{11'h406, 1'b1, 2'b01, 11'h402, 1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 1'b1};
    vecs[3] = '{11'h007, 1'b0, 2'b01, 11'h001, 1'b1, 2'b11, 2'b00, 1'b1, 2'b01, 1'b1};

    // Reset: outputs forced low even with everything requesting.
    idle_all();
    s0.aw_valid = 1'b1; s1.ar_valid = 1'b1; s0.w_valid = 1'b1; s1.w_valid = 1'b1;
    m.aw_ready = 1'b1; m.ar_ready = 1'b1; m.w_ready = 1'b1;
    m.b_valid = 1'b1; m.b_id = 11'h400; m.r_valid = 1'b1; m.r_id = 11'h000;
    #12;
    chk("rst_mst_aw_valid", 64'(m.aw_valid), 0);
    chk("rst_mst_ar_valid", 64'(m.ar_valid), 0);
    chk("rst_mst_w_valid", 64'(m.w_valid), 0);
    chk("rst_s0_aw_ready", 64'(s0.aw_ready), 0);
    chk("rst_s1_ar_ready", 64'(s1.ar_ready), 0);
    chk("rst_w_ready", 64'({s1.w_ready, s0.w_ready}), 0);
    chk("rst_s1_b_valid", 64'(s1.b_valid), 0);
    chk("rst_s0_r_valid", 64'(s0.r_valid), 0);
    next_cycle();
    idle_all();
    rst_n = 1'b1;

    // Simultaneous AW after reset: port 0 first, then port 1 after the W beat.
    next_cycle();
    m.aw_ready = 1'b1; m.w_ready = 1'b1;
    set_aw(0, 1'b1, 10'h012, 32'h1000_0000, 8'd0); set_aw(1, 1'b1, 10'h02A, 32'h2000_0000, 8'd0);
    set_w(0, 1'b1, 64'hA0, 1'b1); set_w(1, 1'b1, 64'hA1, 1'b1);
    aw_q.push_back('{11'h012, 32'h1000_0000, 2'b01});
    aw_q.push_back('{11'h42A, 32'h2000_0000, 2'b10});
    w_q.push_back('{64'hA0, 1'b1, 2'b01});
    w_q.push_back('{64'hA1, 1'b1, 2'b10});
    settle();
    chk("a_idle_w_valid", 64'(m.w_valid), 0);
    chk("a_s0_w_ready_idle", 64'(s0.w_ready), 0);
    chk("a_s1_aw_ready", 64'(s1.aw_ready), 0);
    next_cycle(); s0.aw_valid = 1'b0;
    settle();
    chk("a_data_aw_valid", 64'(m.aw_valid), 0);
    chk("a_s1_aw_ready_data", 64'(s1.aw_ready), 0);
    chk("a_s1_w_ready", 64'(s1.w_ready), 0);
    next_cycle(); s0.w_valid = 1'b0;
    settle();
    chk("a_s1_aw_ready_grant", 64'(s1.aw_ready), 1);
    next_cycle(); s1.aw_valid = 1'b0;
    settle();
    next_cycle(); s1.w_valid = 1'b0;

    // AW hold: port 0 stalled three cycles while port 1 waits.
    set_aw(0, 1'b1, 10'h033, 32'h3000_0000, 8'd0); set_aw(1, 1'b1, 10'h044, 32'h4000_0000, 8'd0);
    m.aw_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("b_hold_aw_id", 64'(m.aw_id), 64'(11'h033));
      chk("b_hold_aw_addr", 64'(m.aw_addr), 64'h3000_0000);
      chk("b_hold_aw_valid", 64'(m.aw_valid), 1);
      next_cycle();
      s1.aw_addr = s1.aw_addr + 32'h10;
    end
    m.aw_ready = 1'b1;
    aw_q.push_back('{11'h033, 32'h3000_0000, 2'b01});
    settle();
    chk("b_s1_aw_ready", 64'(s1.aw_ready), 0);
    next_cycle(); s0.aw_valid = 1'b0;
    set_w(0, 1'b1, 64'hB0, 1'b1);
    w_q.push_back('{64'hB0, 1'b1, 2'b01});
    settle();

    // 4-beat write from port 1 while port 0 holds AW and W.
    next_cycle();
    set_aw(1, 1'b1, 10'h055, 32'h5000_0000, 8'd3);
    set_aw(0, 1'b1, 10'h066, 32'h6000_0000, 8'd0);
    set_w(0, 1'b1, 64'hC0, 1'b1);
    aw_q.push_back('{11'h455, 32'h5000_0000, 2'b10});
    settle();
    chk("c_s0_aw_ready", 64'(s0.aw_ready), 0);
    chk("c_s0_w_ready", 64'(s0.w_ready), 0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k == 0) s1.aw_valid = 1'b0;
      set_w(1, 1'b1, 64'hC10 + 64'(k), k == 3);
      w_q.push_back('{64'hC10 + 64'(k), k == 3, 2'b10});
      settle();
      chk("c_burst_s0_w_ready", 64'(s0.w_ready), 0);
      chk("c_burst_s0_aw_ready", 64'(s0.aw_ready), 0);
    end
    next_cycle(); s1.w_valid = 1'b0;
    aw_q.push_back('{11'h066, 32'h6000_0000, 2'b01});
    settle();
    chk("c_gap_w_valid", 64'(m.w_valid), 0);
    chk("c_s0_aw_ready_after", 64'(s0.aw_ready), 1);
    next_cycle(); s0.aw_valid = 1'b0;
    w_q.push_back('{64'hC0, 1'b1, 2'b01});
    settle();
    next_cycle(); s0.w_valid = 1'b0; m.aw_ready = 1'b0; m.w_ready = 1'b0;

    // Continuous AR from both ports: grants alternate 0,1,0,1.
    m.ar_ready = 1'b1;
    set_ar(0, 1'b1, 10'h101, 32'h7000_0000); set_ar(1, 1'b1, 10'h202, 32'h8000_0000);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cycle();
      if (k % 2 == 0) ar_q.push_back('{11'h101, 32'h7000_0000, 2'b01});
      else            ar_q.push_back('{11'h602, 32'h8000_0000, 2'b10});
      settle();
    end
    next_cycle(); m.ar_ready = 1'b0;
    settle();
    chk("d_hold_ar_id", 64'(m.ar_id), 64'(11'h101));
    next_cycle(); s1.ar_addr = 32'h8000_0100;
    settle();
    chk("d_hold_ar_id_frozen", 64'(m.ar_id), 64'(11'h101));
    next_cycle(); m.ar_ready = 1'b1;
    ar_q.push_back('{11'h101, 32'h7000_0000, 2'b01});
    settle();
    next_cycle(); s0.ar_valid = 1'b0; s1.ar_valid = 1'b0; m.ar_ready = 1'b0;

    // Response steering table.
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      rdat = {$urandom(), $urandom()};
      m.r_id = vecs[i].r_id; m.r_valid = vecs[i].r_valid; m.r_data = rdat;
      s0.r_ready = vecs[i].r_rdy[0]; s1.r_ready = vecs[i].r_rdy[1];
      m.b_id = vecs[i].b_id; m.b_valid = vecs[i].b_valid;
      s0.b_ready = vecs[i].b_rdy[0]; s1.b_ready = vecs[i].b_rdy[1];
      settle();
      chk("e_r_valid", 64'({s1.r_valid, s0.r_valid}), 64'(vecs[i].exp_rv));
      chk("e_r_ready", 64'(m.r_ready), 64'(vecs[i].exp_rr));
      chk("e_b_valid", 64'({s1.b_valid, s0.b_valid}), 64'(vecs[i].exp_bv));
      chk("e_b_ready", 64'(m.b_ready), 64'(vecs[i].exp_br));
      chk("e_r_id_low", 64'(s1.r_id), 64'(vecs[i].r_id[9:0]));
      chk("e_b_id_low", 64'(s0.b_id), 64'(vecs[i].b_id[9:0]));
      chk("e_r_data", s0.r_data, rdat);
    end
    next_cycle();
    idle_all();

    // Reset in WR_DATA mid-burst.
    m.aw_ready = 1'b1; m.w_ready = 1'b1;
    set_aw(1, 1'b1, 10'h077, 32'h9000_0000, 8'd3);
    aw_q.push_back('{11'h477, 32'h9000_0000, 2'b10});
    settle();
    next_cycle(); s1.aw_valid = 1'b0;
    set_w(1, 1'b1, 64'hF0, 1'b0);
    w_q.push_back('{64'hF0, 1'b0, 2'b10});
    settle();
    next_cycle();
    set_w(1, 1'b1, 64'hF1, 1'b0);
    s0.aw_valid = 1'b1; s0.ar_valid = 1'b1; m.ar_ready = 1'b1;
    m.b_valid = 1'b1; m.b_id = 11'h400; m.r_valid = 1'b1; m.r_id = 11'h000;
    #1;
    chk("f_pre_w_valid", 64'(m.w_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("f_rst_w_valid", 64'(m.w_valid), 0);
    chk("f_rst_s1_w_ready", 64'(s1.w_ready), 0);
    chk("f_rst_aw_ready", 64'({s1.aw_ready, s0.aw_ready}), 0);
    chk("f_rst_s0_ar_ready", 64'(s0.ar_ready), 0);
    chk("f_rst_mst_valid", 64'({m.aw_valid, m.ar_valid}), 0);
    chk("f_rst_resp_valid", 64'({s1.b_valid, s0.r_valid}), 0);
    next_cycle();
    s0.ar_valid = 1'b0; m.ar_ready = 1'b0; m.b_valid = 1'b0; m.r_valid = 1'b0; m.aw_ready = 1'b0;
    set_aw(0, 1'b1, 10'h088, 32'hA000_0000, 8'd0);
    set_aw(1, 1'b1, 10'h099, 32'hB000_0000, 8'd0);
    rst_n = 1'b1;
    settle();
    chk("f_rel_aw_id", 64'(m.aw_id), 64'(11'h088));
    chk("f_rel_w_valid", 64'(m.w_valid), 0);
    chk("f_rel_s1_w_ready", 64'(s1.w_ready), 0);
    next_cycle();
    idle_all();
    settle();

    chk("aw_q_drained", 64'(aw_q.size()), 0);
    chk("ar_q_drained", 64'(ar_q.size()), 0);
    chk("w_q_drained", 64'(w_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_rr_arb_2to1.md
Name: axi_rr_arb_2to1

Overview:
- Two-to-one AXI4 arbiter: two upstream masters share one downstream AXI_BUS slave port, e.g. core data port and debug/DMA port sharing the memory/peripheral interconnect.
- Independent round-robin arbitration on the AW and AR channels.
- The W channel is locked to the granted writer until w_last.
- B/R responses are routed back using one ID bit the arbiter prepends on the downstream side.
- Address/data paths are combinational pass-through; only grant and lock state is registered.

Parameters:
- AXI_ADDR_WIDTH, 32: address width, all ports.
- AXI_DATA_WIDTH, 64: data width, all ports; strobe width is AXI_DATA_WIDTH/8.
- AXI_ID_WIDTH, 10: ID width of the upstream ports; the downstream ID width is AXI_ID_WIDTH+1.
- AXI_USER_WIDTH, 6: user width, all ports.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- slv0  AXI_BUS.Slave  (AXI_ID_WIDTH)  upstream master 0; wins ties after reset.
- slv1  AXI_BUS.Slave  (AXI_ID_WIDTH)  upstream master 1.
- mst  AXI_BUS.Master  (AXI_ID_WIDTH+1)  downstream shared port.

Behaviour:

Reset (async assert, sync release):
- Write FSM = WR_IDLE, read FSM = RD_IDLE, both rr pointers = 0 (port 0 preferred).
- While rst_n=0 these are forced low: mst.aw_valid, mst.ar_valid, mst.w_valid, all upstream aw_ready/ar_ready/w_ready/b_valid/r_valid.
- Reset mid-burst abandons the transaction; there is no recovery or replay.

ID rules:
- Downstream aw_id/ar_id = {port_idx, upstream_id}.
- Returned b_id/r_id MSB selects the target port; the lower AXI_ID_WIDTH bits go upstream unchanged.

Write FSM (states WR_IDLE, WR_AWHOLD, WR_DATA):
- WR_IDLE: when any aw_valid is high, select a port. If only one requests, it wins. If both request, the port equal to wr_ptr wins.
  - Selected AW fields drive mst.aw_*; selected aw_ready = mst.aw_ready; the other port's aw_ready = 0.
  - AW handshake in the same cycle: go to WR_DATA, latch wsel, set wr_ptr = ~wsel.
  - No handshake: latch the selection and go to WR_AWHOLD.
- WR_AWHOLD: grant is frozen; mst.aw_valid stays asserted with unchanged fields (AXI stability). Deassertion of upstream aw_valid is a protocol violation and is not checked. On handshake go to WR_DATA, then wr_ptr = ~wsel.
- WR_DATA:
  - mst.w_* = port wsel's W signals; wsel w_ready = mst.w_ready; other port w_ready = 0.
  - Both aw_ready = 0; mst.aw_valid = 0.
  - On a handshake with w_last=1, go to WR_IDLE; the next arbitration is in the following cycle.
- In WR_IDLE/WR_AWHOLD, mst.w_valid = 0 and both w_ready = 0. Early W data waits upstream.

Read FSM (states RD_IDLE, RD_HOLD):
- Same arbitration as AW, using rd_ptr.
- RD_IDLE: handshake in the same cycle updates rd_ptr and stays in RD_IDLE; otherwise go to RD_HOLD with the grant frozen until handshake, then back to RD_IDLE.
- Multiple outstanding reads are allowed; there is no burst lock on reads.

Responses (combinational):
- B: idx = mst.b_id[AXI_ID_WIDTH].
  - slv[idx].b_valid = mst.b_valid; other port b_valid = 0.
  - mst.b_ready = slv[idx].b_ready.
  - b_resp and b_user broadcast to both ports.
- R: same rule using r_id MSB; r_data, r_resp, r_last, r_user broadcast; r_valid/r_ready steered.

Simultaneous events:
- AW and AR arbitration are fully independent; both may grant the same or different ports in the same cycle.
- B/R delivery is never blocked by the FSM state.

Latency:
- Zero-cycle forward pass on all channels.
- One idle cycle between the last W beat and the next AW grant.

Test Plan:
- Both masters assert aw_valid at the same time after reset, len=0, mst.aw_ready=1. Required: port 0 granted first with mst.aw_id = {1'b0, id0}; after its w_last, port 1 granted with id {1'b1, id1}; wr_ptr returns to 0.
- Port 0 aw_valid with mst.aw_ready held 0 for 3 cycles while port 1 raises aw_valid. Required: mst.aw_addr/aw_id stay at port 0 values; port 1 aw_ready = 0 throughout.
- 4-beat write (len=3) from port 1 while port 0 holds aw_valid and w_valid. Required: port 0 w_ready = 0 and aw_ready = 0 until port 1 w_last handshake; port 0 AW granted one cycle later.
- Interleaved read responses with r_id = {1,5}, {0,7}, {1,6}. Required: r_valid asserted on slv1 (id 5), slv0 (id 7), slv1 (id 6) respectively; mst.r_ready tracks the selected port's r_ready.
- Continuous ar_valid from both ports, mst.ar_ready=1. Required: grants alternate 0,1,0,1 with one handshake per cycle.
- rst_n pulled low in WR_DATA mid-burst. Required: mst.w_valid and all ready signals drop immediately; after release, state is WR_IDLE with port 0 preferred.
